// File: rtl/cpu_core_p.sv
// cpu_core_p: serial-instruction core with a parametrised register file and ZF/SF/CF flags.
// Instructions arrive MSB first after a start bit. Each one retires in a single EXEC cycle.
module cpu_core_p #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins,
  output logic [NREG*W-1:0] regs,
  output logic              zf,
  output logic              sf,
  output logic              cf,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RA = $clog2(NREG);
  localparam int unsigned IW = 4 + 2 * RA + W;
  localparam int unsigned CW = $clog2(IW);
  localparam logic [CW-1:0] CNT_LAST = CW'(IW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  sr;
  logic [W-1:0]   rf [NREG];

  logic           start_c;
  logic           shift_en_c;
  logic           exec_en_c;

  logic [3:0]     op;
  logic [RA-1:0]  rd;
  logic [RA-1:0]  rs;
  logic [W-1:0]   imm;
  logic           rd_ok_c;
  logic           rs_ok_c;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;

  logic [W-1:0]   res;
  logic [W:0]     ext;
  logic           we;
  logic           upd_zs;
  logic           upd_c;
  logic           c_new;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start bit, IW data bits, one execute cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ins) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decodes that steer the datapath
  always_comb begin
    start_c    = 1'b0;
    shift_en_c = 1'b0;
    exec_en_c  = 1'b0;
    case (state)
      IDLE:    start_c    = ins;
      SHIFT:   shift_en_c = 1'b1;
      EXEC:    exec_en_c  = 1'b1;
      default: ;
    endcase
  end

  // Bit counter and instruction shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (start_c) begin
      cnt <= '0;
    end else if (shift_en_c) begin
      sr  <= {sr[IW-2:0], ins};
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Field extraction; out-of-range register indices read as zero
  assign op      = sr[IW-1 -: 4];
  assign rd      = sr[2*RA+W-1 -: RA];
  assign rs      = sr[RA+W-1 -: RA];
  assign imm     = sr[W-1:0];
  assign rd_ok_c = (32'(rd) < NREG);
  assign rs_ok_c = (32'(rs) < NREG);
  assign opa     = rd_ok_c ? rf[rd] : '0;
  assign opb     = rs_ok_c ? rf[rs] : '0;

  // ALU: result, write enable and per-opcode flag update rules
  always_comb begin
    res    = '0;
    ext    = '0;
    we     = 1'b0;
    upd_zs = 1'b0;
    upd_c  = 1'b0;
    c_new  = 1'b0;
    case (op)
      4'd1:  begin res = opb; we = 1'b1; upd_zs = 1'b1; end
      4'd2:  begin res = imm; we = 1'b1; upd_zs = 1'b1; end
      4'd3:  begin
        ext = {1'b0, opa} + {1'b0, opb};
        res = ext[W-1:0]; c_new = ext[W]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd4:  begin
        ext = {1'b0, opa} - {1'b0, opb};
        res = ext[W-1:0]; c_new = ext[W]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd5:  begin res = opa & opb; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1; end
      4'd6:  begin res = opa | opb; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1; end
      4'd7:  begin res = opa ^ opb; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1; end
      4'd8:  begin res = ~opb;      we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1; end
      4'd9:  begin
        res = {opa[W-2:0], 1'b0}; c_new = opa[W-1]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd10: begin
        res = {1'b0, opa[W-1:1]}; c_new = opa[0]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd11: begin
        ext = {1'b0, opa} + {1'b0, imm};
        res = ext[W-1:0]; c_new = ext[W]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd12: begin
        ext = {1'b0, opa} - {1'b0, opb};
        res = ext[W-1:0]; c_new = ext[W]; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd13: begin
        ext = {1'b0, opa} + (W+1)'(1);
        res = ext[W-1:0]; c_new = ext[W]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      4'd14: begin
        ext = {1'b0, opa} - (W+1)'(1);
        res = ext[W-1:0]; c_new = ext[W]; we = 1'b1; upd_zs = 1'b1; upd_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file and flags commit in the EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      zf <= 1'b0;
      sf <= 1'b0;
      cf <= 1'b0;
    end else if (exec_en_c) begin
      if (we && rd_ok_c) rf[rd] <= res;
      if (upd_zs) begin
        zf <= (res == '0);
        sf <= res[W-1];
      end
      if (upd_c) cf <= c_new;
    end
  end

  // Status outputs: busy follows the next state, done marks retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= exec_en_c;
    end
  end

  // Flattened register view
  for (genvar g = 0; g < int'(NREG); g++) begin : g_regs
    assign regs[g*W +: W] = rf[g];
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed vector table plus hand-written reset and wide-config sequences.
module tb_cpu_core_p;

  logic         clk;
  logic         rst_n;
  logic         ins0;
  logic         ins1;
  logic [31:0]  regs0;
  logic [127:0] regs1;
  logic         zf0, sf0, cf0, busy0, done0;
  logic         zf1, sf1, cf1, busy1, done1;

  int nchk;
  int nerr;

  cpu_core_p #(.W(8), .NREG(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ins(ins0), .regs(regs0),
    .zf(zf0), .sf(sf0), .cf(cf0), .busy(busy0), .done(done0)
  );

  cpu_core_p #(.W(16), .NREG(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ins(ins1), .regs(regs1),
    .zf(zf1), .sf(sf1), .cf(cf1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       b2b;   // next instruction's start bit goes out in this one's done cycle
    logic [1:0] creg;
    logic [7:0] val;
    logic [2:0] zsc;   // expected {zf, sf, cf}
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc8(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
    return {16'h0, op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc16(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [15:0] imm);
    return {6'h0, op, rd, rs, imm};
  endfunction

  task automatic add(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                     input logic [7:0] imm, input logic b2b, input logic [1:0] creg,
                     input logic [7:0] val, input logic [2:0] zsc);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.b2b = b2b;
    v.creg = creg; v.val = val; v.zsc = zsc;
    vq.push_back(v);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) ins1 = v;
    else     ins0 = v;
  endtask

  // Sends one instruction and checks busy/done timing cycle by cycle.
  // chain=1: the start bit is already on the line at the current negedge.
  // Returns at the negedge where done must be high; ins is then left at next_start.
  task automatic run_instr(input bit sel, input int iw, input logic [31:0] instr,
                           input bit chain, input bit next_start, input string name);
    bit   ok;
    logic d, b;
    ok = 1'b1;
    if (!chain) begin
      @(negedge clk);
      drive(sel, 1'b1);
    end
    for (int k = 1; k <= iw; k++) begin
      @(negedge clk);
      drive(sel, instr[iw-k]);
      d = sel ? done1 : done0;
      b = sel ? busy1 : busy0;
      if (d !== 1'b0 || b !== 1'b1) ok = 1'b0;
    end
    @(negedge clk);
    drive(sel, 1'b1);   // EXEC cycle: must be ignored
    d = sel ? done1 : done0;
    b = sel ? busy1 : busy0;
    if (d !== 1'b0 || b !== 1'b1) ok = 1'b0;
    @(negedge clk);
    drive(sel, next_start);
    d = sel ? done1 : done0;
    b = sel ? busy1 : busy0;
    chk({name, ".timing(ok,done,busy)"}, {125'h0, ok, d, b}, 128'b110);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ndone;
    int   nbusy;
    bit   chain;
    vec_t v;
    logic [31:0] ins_ldi;

    nchk  = 0;
    nerr  = 0;
    ins0  = 1'b0;
    ins1  = 1'b0;
    rst_n = 1'b0;

    // opcode rd rs imm b2b creg val {zf,sf,cf}
    add(4'd2,  2'd0, 2'd0, 8'h7F, 1'b1, 2'd0, 8'h7F, 3'b000); // LDI r0,7F
    add(4'd11, 2'd0, 2'd0, 8'h01, 1'b0, 2'd0, 8'h80, 3'b010); // ADDI r0,1
    add(4'd2,  2'd1, 2'd0, 8'hFF, 1'b1, 2'd1, 8'hFF, 3'b010); // LDI r1,FF
    add(4'd13, 2'd1, 2'd0, 8'h00, 1'b0, 2'd1, 8'h00, 3'b101); // INC r1
    add(4'd12, 2'd2, 2'd1, 8'h00, 1'b0, 2'd2, 8'h00, 3'b100); // CMP r2,r1
    add(4'd2,  2'd3, 2'd0, 8'h81, 1'b1, 2'd3, 8'h81, 3'b010); // LDI r3,81
    add(4'd10, 2'd3, 2'd0, 8'h00, 1'b0, 2'd3, 8'h40, 3'b001); // SHR r3
    add(4'd2,  2'd0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 3'b101); // LDI r0,0
    add(4'd4,  2'd0, 2'd3, 8'h00, 1'b0, 2'd0, 8'hC0, 3'b011); // SUB r0,r3
    add(4'd1,  2'd1, 2'd3, 8'h00, 1'b1, 2'd1, 8'h40, 3'b001); // MOV r1,r3
    add(4'd5,  2'd0, 2'd3, 8'h00, 1'b0, 2'd0, 8'h40, 3'b000); // AND r0,r3
    add(4'd7,  2'd0, 2'd1, 8'h00, 1'b1, 2'd0, 8'h00, 3'b100); // XOR r0,r1
    add(4'd6,  2'd2, 2'd3, 8'h00, 1'b0, 2'd2, 8'h40, 3'b000); // OR r2,r3
    add(4'd8,  2'd2, 2'd3, 8'h00, 1'b0, 2'd2, 8'hBF, 3'b010); // NOT r2,r3
    add(4'd9,  2'd2, 2'd0, 8'h00, 1'b1, 2'd2, 8'h7E, 3'b001); // SHL r2
    add(4'd14, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 8'hFF, 3'b011); // DEC r0
    add(4'd3,  2'd3, 2'd3, 8'h00, 1'b0, 2'd3, 8'h80, 3'b010); // ADD r3,r3
    add(4'd3,  2'd0, 2'd3, 8'h00, 1'b1, 2'd0, 8'h7F, 3'b001); // ADD r0,r3
    add(4'd0,  2'd0, 2'd1, 8'hAA, 1'b0, 2'd0, 8'h7F, 3'b001); // NOP
    add(4'd15, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h7F, 3'b001); // reserved
    add(4'd12, 2'd3, 2'd0, 8'h00, 1'b0, 2'd3, 8'h80, 3'b000); // CMP r3,r0

    // Reset values, then 50 idle cycles
    repeat (3) @(negedge clk);
    chk("rst.regs",      {96'h0, regs0}, 128'h0);
    chk("rst.flags",     {125'h0, zf0, sf0, cf0}, 128'h0);
    chk("rst.busy_done", {126'h0, busy0, done0}, 128'h0);
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    repeat (50) begin
      @(negedge clk);
      if (done0) ndone++;
      if (busy0) nbusy++;
    end
    chk("idle.done_count", 128'(ndone), 128'h0);
    chk("idle.busy_count", 128'(nbusy), 128'h0);
    chk("idle.regs", {96'h0, regs0}, 128'h0);

    // Directed vector table
    for (int i = 0; i < vq.size(); i++) begin
      v     = vq[i];
      chain = (i > 0) ? vq[i-1].b2b : 1'b0;
      run_instr(1'b0, 16, enc8(v.op, v.rd, v.rs, v.imm), chain, v.b2b, $sformatf("v%0d", i));
      chk($sformatf("v%0d.reg", i), {120'h0, regs0[v.creg*8 +: 8]}, {120'h0, v.val});
      chk($sformatf("v%0d.flags", i), {125'h0, zf0, sf0, cf0}, {125'h0, v.zsc});
    end
    chk("table.regs_bus", {96'h0, regs0}, {96'h0, 32'h807E407F});

    // Reset after 9 instruction bits of LDI r2,55
    ins_ldi = enc8(4'd2, 2'd2, 2'd0, 8'h55);
    @(negedge clk);
    ins0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ins0 = ins_ldi[16-k];
    end
    @(negedge clk);
    ins0  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.regs",      {96'h0, regs0}, 128'h0);
    chk("midrst.flags",     {125'h0, zf0, sf0, cf0}, 128'h0);
    chk("midrst.busy_done", {126'h0, busy0, done0}, 128'h0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("midrst.no_done", 128'(ndone), 128'h0);
    chk("midrst.r2", {120'h0, regs0[23:16]}, 128'h0);
    // Release and present the start bit for the first rising edge
    rst_n = 1'b1;
    ins0  = 1'b1;
    run_instr(1'b0, 16, ins_ldi, 1'b1, 1'b0, "postrst");
    chk("postrst.r2",    {120'h0, regs0[23:16]}, 128'h55);
    chk("postrst.flags", {125'h0, zf0, sf0, cf0}, 128'h0);

    // Wide configuration: W=16, NREG=8, IW=26
    run_instr(1'b1, 26, enc16(4'd2, 3'd7, 3'd0, 16'h8000), 1'b0, 1'b1, "w16.ldi");
    chk("w16.ldi.r7",    {112'h0, regs1[127:112]}, 128'h8000);
    chk("w16.ldi.bus",   regs1, {16'h8000, 112'h0});
    chk("w16.ldi.flags", {125'h0, zf1, sf1, cf1}, 128'b010);
    run_instr(1'b1, 26, enc16(4'd3, 3'd7, 3'd7, 16'h0000), 1'b1, 1'b0, "w16.add");
    chk("w16.add.bus",   regs1, 128'h0);
    chk("w16.add.flags", {125'h0, zf1, sf1, cf1}, 128'b101);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
